// File: rtl/cordic_ln_arbiter.sv
// cordic_ln_arbiter
// Shares one pipelined CORDIC ln unit among NUM_REQ requesters. The block
// sequences the unit's reset and ROM warm-up, then grants at most one
// requester per cycle in round-robin order. A tag pipeline matched to the
// unit latency carries each operand's valid bit and requester ID, so the
// result can be routed back to the requester that issued it.
//
// Optional build macro: CORDIC_LN_ARB_STATS_EN adds the saturating
// stat_issued / stat_zero counters and their output ports.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// UNIT_RST  | ln_rst_n held low for UNIT_RST_CYCLES
// WARMUP    | ln unit out of reset, waiting WARMUP_CYCLES for ROM load
// RUN       | round-robin grants, one operand per cycle
// DRAIN     | no grants; waiting for in-flight ops to return
// DRAINED   | empty and idle; leaving drain resumes RUN without warm-up
module cordic_ln_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int FRAC_WIDTH      = 16,
   parameter int PIPE_LATENCY    = 11,
   parameter int UNIT_RST_CYCLES = 2,
   parameter int WARMUP_CYCLES   = 12
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          drain,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          ln_rst_n,
   output logic [DATA_WIDTH-1:0]         ln_r_in,
   input  logic [DATA_WIDTH-1:0]         ln_r_out,
   output logic                          busy,
   output logic                          idle
`ifdef CORDIC_LN_ARB_STATS_EN
   ,
   output logic [31:0]                   stat_issued,
   output logic [31:0]                   stat_zero
`endif
);

   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int CW      = ID_W + 1;
   localparam int CNT_MAX = (UNIT_RST_CYCLES > WARMUP_CYCLES) ? UNIT_RST_CYCLES : WARMUP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int LAST    = PIPE_LATENCY - 1;

   // Fixed-point format is only carried through; it still has to be sane.
   if (NUM_REQ < 2 || NUM_REQ > 8 || FRAC_WIDTH >= DATA_WIDTH || PIPE_LATENCY < 1 ||
       UNIT_RST_CYCLES < 1 || WARMUP_CYCLES < 1) begin : g_bad_params
      $error("cordic_ln_arbiter: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      ST_UNIT_RST,
      ST_WARMUP,
      ST_RUN,
      ST_DRAIN,
      ST_DRAINED
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ID_W-1:0]         ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0]   ln_r_in_q, ln_r_in_d;
   logic [PIPE_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [ID_W-1:0]         tag_id_q [PIPE_LATENCY];
   logic [ID_W-1:0]         tag_id_d [PIPE_LATENCY];
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

   logic                    grant_en;
   logic                    grant_hit;
   logic [ID_W-1:0]         grant_id;
   logic [CW-1:0]           cand;
   logic                    hs;
   logic                    tag_any;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

   // Round-robin search: first valid requester after the pointer, wrapping.
   always_comb begin
      grant_hit = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = {1'b0, ptr_q} + CW'(off);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (!grant_hit && req_valid[cand[ID_W-1:0]]) begin
            grant_hit = 1'b1;
            grant_id  = cand[ID_W-1:0];
         end
      end
   end

   assign grant_en  = (state_q == ST_RUN) && !drain;
   assign hs        = grant_en && grant_hit;
   assign req_ready = hs ? onehot(grant_id) : '0;
   assign tag_any   = |tag_vld_q;

   // Sequencer next-state: unit reset, warm-up, run, drain handling.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_UNIT_RST: begin
            if (cnt_q == '0) begin
               state_d = ST_WARMUP;
               cnt_d   = CNT_W'(WARMUP_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WARMUP: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RUN: begin
            if (drain) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!tag_any && (rsp_valid_q == '0)) begin
               state_d = ST_DRAINED;
            end
         end
         ST_DRAINED: begin
            if (!drain) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_UNIT_RST;
            cnt_d   = CNT_W'(UNIT_RST_CYCLES - 1);
         end
      endcase
   end

   // Issue, tag shift and result routing; rsp_data only moves on a valid tag.
   always_comb begin
      ln_r_in_d   = '0;
      ptr_d       = ptr_q;
      tag_vld_d   = '0;
      tag_id_d    = '{default: '0};
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;

      if (hs) begin
         ln_r_in_d = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
         ptr_d     = grant_id;
      end

      tag_vld_d[0] = hs;
      tag_id_d[0]  = hs ? grant_id : '0;
      for (int s = 1; s < PIPE_LATENCY; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end

      if (tag_vld_q[LAST]) begin
         rsp_valid_d = onehot(tag_id_q[LAST]);
         rsp_data_d  = ln_r_out;
      end
   end

   // Control and result registers; a reset drops every in-flight tag.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_UNIT_RST;
         cnt_q       <= CNT_W'(UNIT_RST_CYCLES - 1);
         ptr_q       <= ID_W'(NUM_REQ - 1);
         ln_r_in_q   <= '0;
         tag_vld_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         ln_r_in_q   <= ln_r_in_d;
         tag_vld_q   <= tag_vld_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Tag IDs are qualified by tag_vld_q, so they need no reset.
   always_ff @(posedge sys_clk) begin
      tag_id_q <= tag_id_d;
   end

   assign ln_rst_n  = (state_q != ST_UNIT_RST);
   assign ln_r_in   = ln_r_in_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != ST_RUN) || tag_any || (rsp_valid_q != '0);
   assign idle      = (state_q == ST_DRAINED);

`ifdef CORDIC_LN_ARB_STATS_EN
   logic [31:0] stat_issued_q, stat_issued_d;
   logic [31:0] stat_zero_q, stat_zero_d;

   // Saturating counts of accepted operands and of accepted zeros.
   always_comb begin
      stat_issued_d = stat_issued_q;
      stat_zero_d   = stat_zero_q;
      if (hs && (stat_issued_q != '1)) begin
         stat_issued_d = stat_issued_q + 32'd1;
      end
      if (hs && (ln_r_in_d == '0) && (stat_zero_q != '1)) begin
         stat_zero_d = stat_zero_q + 32'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         stat_issued_q <= '0;
         stat_zero_q   <= '0;
      end else begin
         stat_issued_q <= stat_issued_d;
         stat_zero_q   <= stat_zero_d;
      end
   end

   assign stat_issued = stat_issued_q;
   assign stat_zero   = stat_zero_q;
`endif

endmodule

// File: tb/tb_cordic_ln_arbiter.sv
// Testbench for cordic_ln_arbiter: behavioural ln unit, per-cycle grant and
// sequencing model, and a global-order response scoreboard.
module tb_cordic_ln_arbiter;

   localparam int NR        = 4;
   localparam int DW        = 32;
   localparam int FW        = 16;
   localparam int PL        = 11;
   localparam int URC       = 2;
   localparam int WUC       = 12;
   localparam int LAT       = PL + 1;
   localparam int FIRST_RUN = URC + WUC;
   localparam logic signed [DW-1:0] LN_EPS = -2362156;

   localparam int PH_SEQ     = 0;
   localparam int PH_RUN     = 1;
   localparam int PH_DRAIN   = 2;
   localparam int PH_DRAINED = 3;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              drain;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              ln_rst_n;
   logic [DW-1:0]     ln_r_in;
   logic [DW-1:0]     ln_r_out;
   logic              busy;
   logic              idle;
`ifdef CORDIC_LN_ARB_STATS_EN
   logic [31:0]       stat_issued;
   logic [31:0]       stat_zero;
`endif

   always #5 sys_clk = ~sys_clk;

   cordic_ln_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .FRAC_WIDTH(FW), .PIPE_LATENCY(PL),
      .UNIT_RST_CYCLES(URC), .WARMUP_CYCLES(WUC)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .drain(drain), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ln_rst_n(ln_rst_n), .ln_r_in(ln_r_in), .ln_r_out(ln_r_out), .busy(busy), .idle(idle)
`ifdef CORDIC_LN_ARB_STATS_EN
      , .stat_issued(stat_issued), .stat_zero(stat_zero)
`endif
   );

   // Reference ln in Q16.16: round(ln(|x|) * 2^16), zero gives LN_EPS.
   function automatic logic [DW-1:0] ln_ref(input logic [DW-1:0] x);
      longint a;
      real    r;
      int     q;
      a = longint'($signed(x));
      if (a < 0) a = -a;
      if (a == 0) return LN_EPS;
      r = $ln(real'(a) / 65536.0) * 65536.0;
      q = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      return DW'(q);
   endfunction

   // ln unit model: result appears PL-1 edges after the operand register.
   logic [DW-1:0] u_sr [PL-1];
   always @(posedge sys_clk) begin
      u_sr[0] <= ln_ref(ln_r_in);
      for (int k = 1; k < PL - 1; k++) u_sr[k] <= u_sr[k-1];
   end
   assign ln_r_out = u_sr[PL-2];

   typedef struct {
      int            id;
      logic [DW-1:0] val;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] pend [NR][$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            m_phase = PH_SEQ;
   int            m_t = 0;
   int            m_ptr = NR - 1;
   logic          m_infl = 1'b0;
   logic [NR-1:0] m_hs = '0;
   int            m_issued = 0;
   int            m_zero = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit pend_any();
      for (int i = 0; i < NR; i++) if (pend[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   // Response monitor: expected one-hot valid each cycle, data in issue order.
   initial begin
      exp_t          e;
      logic [NR-1:0] exp_v;
      @(posedge sys_clk);
      forever begin
         @(negedge sys_clk);
         m_infl = (sb.size() > 0);
         exp_v  = '0;
         if (sb.size() > 0 && sb[0].due == cyc) exp_v[sb[0].id] = 1'b1;
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
         if (exp_v != '0) begin
            e = sb.pop_front();
            chk("rsp_data", 64'(rsp_data), 64'(e.val));
         end
      end
   end

   // Arbiter/sequencer model: expected grant, status, then next phase.
   initial begin
      logic [NR-1:0] exp_rdy;
      int            gid;
      int            k;
      exp_t          e;
      @(posedge sys_clk);
      forever begin
         @(negedge sys_clk);
         #1;
         exp_rdy = '0;
         gid     = -1;
         if (m_phase == PH_RUN && !drain) begin
            for (int off = 1; off <= NR; off++) begin
               k = (m_ptr + off) % NR;
               if (req_valid[k]) begin
                  exp_rdy[k] = 1'b1;
                  gid        = k;
                  break;
               end
            end
         end
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("ln_rst_n", 64'(ln_rst_n), 64'(!(m_phase == PH_SEQ && m_t < URC)));
         chk("busy", 64'(busy), 64'((m_phase != PH_RUN) || m_infl));
         chk("idle", 64'(idle), 64'(m_phase == PH_DRAINED));
         m_hs = exp_rdy;
         if (gid >= 0) begin
            e.id  = gid;
            e.val = ln_ref(req_data[gid*DW +: DW]);
            e.due = cyc + LAT;
            sb.push_back(e);
            m_ptr = gid;
            m_issued++;
            if (req_data[gid*DW +: DW] == '0) m_zero++;
         end
         if (sys_rst) begin
            m_phase  = PH_SEQ;
            m_t      = 0;
            m_ptr    = NR - 1;
            m_issued = 0;
            m_zero   = 0;
            sb.delete();
         end else begin
            case (m_phase)
               PH_SEQ: begin
                  m_t++;
                  if (m_t == FIRST_RUN) m_phase = PH_RUN;
               end
               PH_RUN:     if (drain) m_phase = PH_DRAIN;
               PH_DRAIN:   if (!m_infl) m_phase = PH_DRAINED;
               PH_DRAINED: if (!drain) m_phase = PH_RUN;
               default:    m_phase = PH_SEQ;
            endcase
         end
         cyc++;
      end
   end

   // Requester driver: present the head of each pending queue, hold until granted.
   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (m_hs[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            req_valid[i] = (pend[i].size() > 0);
            req_data[i*DW +: DW] = (pend[i].size() > 0) ? pend[i][0] : '0;
         end
      end
   end

   task automatic wait_done(input string name, input int budget);
      int k;
      k = 0;
      while ((sb.size() > 0 || pend_any()) && k < budget) begin
         step(1);
         k++;
      end
      chk({"done_", name}, 64'(sb.size() > 0 || pend_any()), 64'(0));
      step(2);
   endtask

   function automatic logic [DW-1:0] rand_op();
      logic [DW-1:0] v;
      case ($urandom_range(0, 4))
         0:       v = '0;
         1:       v = DW'(32'h0001_0000);
         2:       v = -DW'($urandom_range(1, 32'h00ff_ffff));
         default: v = DW'($urandom);
      endcase
      return v;
   endfunction

   task automatic load_all(input int per_req);
      for (int i = 0; i < NR; i++)
         for (int j = 0; j < per_req; j++) pend[i].push_back(rand_op());
   endtask

   initial begin
      int k;
      sys_rst   = 1'b1;
      drain     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      pend[0].push_back(32'h0001_0000);
      pend[0].push_back(32'h0002_0000);
      pend[0].push_back(32'h0000_0000);
      step(3);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_ln_r_in", 64'(ln_r_in), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_busy_idle", 64'({busy, idle, ln_rst_n}), 64'(3'b100));
      sys_rst = 1'b0;
      wait_done("warmup_values", 100);

      load_all(2);
      wait_done("round_robin", 100);

      pend[2].push_back(rand_op());
      step(2);
      pend[0].push_back(rand_op());
      pend[2].push_back(rand_op());
      wait_done("sparse", 100);

      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NR; i++)
            if (pend[i].size() < 3 && $urandom_range(0, 99) < 30) pend[i].push_back(rand_op());
         step(1);
      end
      wait_done("random", 200);

      load_all(3);
      k = 0;
      while (sb.size() < 5 && k < 50) begin
         step(1);
         k++;
      end
      chk("drain_inflight", 64'(sb.size() >= 5), 64'(1));
      drain = 1'b1;
      k = 0;
      while (!idle && k < 100) begin
         step(1);
         k++;
      end
      chk("drain_idle", 64'(idle), 64'(1));
      chk("drain_flushed", 64'(sb.size()), 64'(0));
      step(4);
      drain = 1'b0;
      wait_done("drain_resume", 100);

      load_all(3);
      k = 0;
      while (sb.size() < 6 && k < 50) begin
         step(1);
         k++;
      end
      chk("reset_inflight", 64'(sb.size() >= 6), 64'(1));
      sys_rst = 1'b1;
      step(1);
      sys_rst = 1'b0;
      wait_done("mid_reset", 200);

`ifdef CORDIC_LN_ARB_STATS_EN
      chk("stat_issued", 64'(stat_issued), 64'(m_issued));
      chk("stat_zero", 64'(stat_zero), 64'(m_zero));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
